// File: rtl/poly_loader_pkg.sv
// Shared constants and types for the polygon command loader and its slot banks.
package poly_loader_pkg;

    localparam int unsigned N_POLY           = 4;
    localparam int unsigned WPX              = 7;
    localparam int unsigned WPY              = 6;
    localparam int unsigned WCOLOR           = 6;
    localparam int unsigned POLY_PAYLOAD_LEN = 7;

    typedef enum logic [1:0] {
        OP_POLY   = 2'b00,
        OP_BG     = 2'b01,
        OP_EN     = 2'b10,
        OP_COMMIT = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        POLY_DATA,
        BG_DATA,
        EN_DATA,
        WAIT_SWAP
    } state_t;

    // POLY payload order, one field per byte
    typedef enum logic [2:0] {
        F_COLOR,
        F_V0X,
        F_V0Y,
        F_V1X,
        F_V1Y,
        F_V2X,
        F_V2Y
    } field_t;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/poly_loader_bank.sv
// One polygon slot: shadow register set written field by field, active set loaded by copy strobe.
module poly_bank
    import poly_loader_pkg::*;
#(
    parameter int unsigned WPX    = poly_loader_pkg::WPX,
    parameter int unsigned WPY    = poly_loader_pkg::WPY,
    parameter int unsigned WCOLOR = poly_loader_pkg::WCOLOR,
    parameter int unsigned WD     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_sel,
    input  logic [WD-1:0]     wr_data,
    input  logic              copy,
    output logic [WCOLOR-1:0] color,
    output logic [WPX-1:0]    v0_x,
    output logic [WPY-1:0]    v0_y,
    output logic [WPX-1:0]    v1_x,
    output logic [WPY-1:0]    v1_y,
    output logic [WPX-1:0]    v2_x,
    output logic [WPY-1:0]    v2_y
);

    logic [WCOLOR-1:0] sh_color;
    logic [WPX-1:0]    sh_v0_x, sh_v1_x, sh_v2_x;
    logic [WPY-1:0]    sh_v0_y, sh_v1_y, sh_v2_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_color <= '0;
            sh_v0_x  <= '0;
            sh_v0_y  <= '0;
            sh_v1_x  <= '0;
            sh_v1_y  <= '0;
            sh_v2_x  <= '0;
            sh_v2_y  <= '0;
            color    <= '0;
            v0_x     <= '0;
            v0_y     <= '0;
            v1_x     <= '0;
            v1_y     <= '0;
            v2_x     <= '0;
            v2_y     <= '0;
        end else begin
            if (wr_en) begin
                case (field_t'(wr_sel))
                    F_COLOR: sh_color <= wr_data[WCOLOR-1:0];
                    F_V0X:   sh_v0_x  <= wr_data[WPX-1:0];
                    F_V0Y:   sh_v0_y  <= wr_data[WPY-1:0];
                    F_V1X:   sh_v1_x  <= wr_data[WPX-1:0];
                    F_V1Y:   sh_v1_y  <= wr_data[WPY-1:0];
                    F_V2X:   sh_v2_x  <= wr_data[WPX-1:0];
                    F_V2Y:   sh_v2_y  <= wr_data[WPY-1:0];
                    default: ;
                endcase
            end
            if (copy) begin
                color <= sh_color;
                v0_x  <= sh_v0_x;
                v0_y  <= sh_v0_y;
                v1_x  <= sh_v1_x;
                v1_y  <= sh_v1_y;
                v2_x  <= sh_v2_x;
                v2_y  <= sh_v2_y;
            end
        end
    end

endmodule

// File: rtl/poly_loader.sv
// Byte-stream command parser feeding shadow polygon banks; shadow is copied to active on frame_start after COMMIT.
module poly_loader
    import poly_loader_pkg::*;
#(
    parameter int unsigned N_POLY = poly_loader_pkg::N_POLY,
    parameter int unsigned WPX    = poly_loader_pkg::WPX,
    parameter int unsigned WPY    = poly_loader_pkg::WPY,
    parameter int unsigned WCOLOR = poly_loader_pkg::WCOLOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     frame_start,
    output logic [N_POLY-1:0]        cmp_en,
    output logic [WCOLOR-1:0]        background_color,
    output logic [WCOLOR*N_POLY-1:0] poly_color,
    output logic [WPX*N_POLY-1:0]    v0_x,
    output logic [WPX*N_POLY-1:0]    v1_x,
    output logic [WPX*N_POLY-1:0]    v2_x,
    output logic [WPY*N_POLY-1:0]    v0_y,
    output logic [WPY*N_POLY-1:0]    v1_y,
    output logic [WPY*N_POLY-1:0]    v2_y,
    output logic                     swap_pending,
    output logic                     cmd_error
);

    localparam int unsigned WD = max3(WPX, WPY, WCOLOR);

    state_t            state;
    logic [2:0]        cnt;
    logic [1:0]        slot;
    logic              slot_ok;
    logic [WCOLOR-1:0] sh_bg;
    logic [N_POLY-1:0] sh_en;
    logic              xfer;
    logic              copy;
    logic              poly_wr;
    logic              hdr_slot_ok;

    assign xfer        = in_valid & in_ready;
    assign copy        = (state == WAIT_SWAP) && frame_start;
    assign poly_wr     = xfer && (state == POLY_DATA) && slot_ok;
    assign hdr_slot_ok = ({1'b0, in_data[1:0]} < 3'(N_POLY));

    // in_ready is held low only in WAIT_SWAP, so no transfer can coincide with a copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            slot             <= '0;
            slot_ok          <= 1'b0;
            sh_bg            <= '0;
            sh_en            <= '0;
            background_color <= '0;
            cmp_en           <= '0;
            in_ready         <= 1'b1;
            swap_pending     <= 1'b0;
            cmd_error        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        case (opcode_t'(in_data[7:6]))
                            OP_POLY: begin
                                state   <= POLY_DATA;
                                cnt     <= '0;
                                slot    <= in_data[1:0];
                                slot_ok <= hdr_slot_ok;
                                if (!hdr_slot_ok) cmd_error <= 1'b1;
                            end
                            OP_BG: state <= BG_DATA;
                            OP_EN: state <= EN_DATA;
                            OP_COMMIT: begin
                                state        <= WAIT_SWAP;
                                in_ready     <= 1'b0;
                                swap_pending <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                POLY_DATA: begin
                    if (xfer) begin
                        if (cnt == 3'(POLY_PAYLOAD_LEN - 1)) state <= IDLE;
                        else                                 cnt   <= cnt + 3'd1;
                    end
                end
                BG_DATA: begin
                    if (xfer) begin
                        sh_bg <= in_data[WCOLOR-1:0];
                        state <= IDLE;
                    end
                end
                EN_DATA: begin
                    if (xfer) begin
                        sh_en <= in_data[N_POLY-1:0];
                        state <= IDLE;
                    end
                end
                WAIT_SWAP: begin
                    if (frame_start) begin
                        background_color <= sh_bg;
                        cmp_en           <= sh_en;
                        swap_pending     <= 1'b0;
                        in_ready         <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_POLY; i++) begin : g_slot
        poly_bank #(
            .WPX    (WPX),
            .WPY    (WPY),
            .WCOLOR (WCOLOR),
            .WD     (WD)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (poly_wr && (slot == 2'(i))),
            .wr_sel  (cnt),
            .wr_data (in_data[WD-1:0]),
            .copy    (copy),
            .color   (poly_color[WCOLOR*i +: WCOLOR]),
            .v0_x    (v0_x[WPX*i +: WPX]),
            .v0_y    (v0_y[WPY*i +: WPY]),
            .v1_x    (v1_x[WPX*i +: WPX]),
            .v1_y    (v1_y[WPY*i +: WPY]),
            .v2_x    (v2_x[WPX*i +: WPX]),
            .v2_y    (v2_y[WPY*i +: WPY])
        );
    end

endmodule

// File: tb/tb_poly_loader.sv
// Directed bench for poly_loader: default 4-slot instance plus a 2-slot instance for invalid-slot handling.
module tb_poly_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        frame_start = 1'b0;
    logic [3:0]  cmp_en;
    logic [5:0]  background_color;
    logic [23:0] poly_color;
    logic [27:0] v0_x, v1_x, v2_x;
    logic [23:0] v0_y, v1_y, v2_y;
    logic        swap_pending;
    logic        cmd_error;

    logic [7:0]  in_data2 = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic        frame_start2 = 1'b0;
    logic [1:0]  cmp_en2;
    logic [5:0]  background_color2;
    logic [11:0] poly_color2;
    logic [13:0] v0_x2, v1_x2, v2_x2;
    logic [11:0] v0_y2, v1_y2, v2_y2;
    logic        swap_pending2;
    logic        cmd_error2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    poly_loader u_dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .frame_start      (frame_start),
        .cmp_en           (cmp_en),
        .background_color (background_color),
        .poly_color       (poly_color),
        .v0_x             (v0_x),
        .v1_x             (v1_x),
        .v2_x             (v2_x),
        .v0_y             (v0_y),
        .v1_y             (v1_y),
        .v2_y             (v2_y),
        .swap_pending     (swap_pending),
        .cmd_error        (cmd_error)
    );

    poly_loader #(.N_POLY(2)) u_dut2 (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data2),
        .in_valid         (in_valid2),
        .in_ready         (in_ready2),
        .frame_start      (frame_start2),
        .cmp_en           (cmp_en2),
        .background_color (background_color2),
        .poly_color       (poly_color2),
        .v0_x             (v0_x2),
        .v1_x             (v1_x2),
        .v2_x             (v2_x2),
        .v0_y             (v0_y2),
        .v1_y             (v1_y2),
        .v2_y             (v2_y2),
        .swap_pending     (swap_pending2),
        .cmd_error        (cmd_error2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input bit which, input logic [7:0] b);
        int unsigned n;
        n = 0;
        @(negedge clk);
        if (which) begin in_data2 = b; in_valid2 = 1'b1; end
        else       begin in_data  = b; in_valid  = 1'b1; end
        while (!(which ? in_ready2 : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic pulse_frame(input bit which);
        @(negedge clk);
        if (which) frame_start2 = 1'b1;
        else       frame_start  = 1'b1;
        @(posedge clk);
        #1;
        frame_start  = 1'b0;
        frame_start2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] slot1_bytes [8];
        slot1_bytes = '{8'h01, 8'h30, 8'h10, 8'h05, 8'h40, 8'h05, 8'h20, 8'h30};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_ready",   32'(in_ready), 32'd1);
        check("rst_swap",    32'(swap_pending), 32'd0);
        check("rst_err",     32'(cmd_error), 32'd0);
        check("rst_en",      32'(cmp_en), 32'd0);
        check("rst_bg",      32'(background_color), 32'd0);
        check("rst_color",   32'(poly_color), 32'd0);
        check("rst_v0x",     32'(v0_x), 32'd0);

        // Reset in the middle of a POLY payload
        send_byte(0, 8'h01);
        send_byte(0, 8'h3F);
        send_byte(0, 8'h11);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst_ready", 32'(in_ready), 32'd1);
        send_byte(0, 8'hC0);
        check("midrst_hdr_swap",  32'(swap_pending), 32'd1);
        check("midrst_hdr_ready", 32'(in_ready), 32'd0);
        pulse_frame(0);
        check("midrst_color", 32'(poly_color), 32'd0);
        check("midrst_v0x",   32'(v0_x), 32'd0);
        check("midrst_swapclr", 32'(swap_pending), 32'd0);

        // Load slot 1
        for (int i = 0; i < 8; i++) send_byte(0, slot1_bytes[i]);
        send_byte(0, 8'hC0);
        @(negedge clk);
        check("s1_pre_v0x",  32'(v0_x), 32'd0);
        check("s1_pre_swap", 32'(swap_pending), 32'd1);
        pulse_frame(0);
        check("s1_color", 32'(poly_color), 32'h000C00);
        check("s1_v0x",   32'(v0_x), 32'h0000800);
        check("s1_v0y",   32'(v0_y), 32'h000140);
        check("s1_v1x",   32'(v1_x), 32'h0002000);
        check("s1_v1y",   32'(v1_y), 32'h000140);
        check("s1_v2x",   32'(v2_x), 32'h0001000);
        check("s1_v2y",   32'(v2_y), 32'h000C00);
        check("s1_swap",  32'(swap_pending), 32'd0);
        check("s1_ready", 32'(in_ready), 32'd1);

        // Backpressure while waiting for the swap
        send_byte(0, 8'hC0);
        @(negedge clk);
        in_data  = 8'h40;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_swap",  32'(swap_pending), 32'd1);
        check("bp_bg",    32'(background_color), 32'd0);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check("bp_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_byte(0, 8'h15);
        send_byte(0, 8'hC0);
        pulse_frame(0);
        check("bp_bg_after", 32'(background_color), 32'h15);

        // COMMIT coincident with frame_start does not swap
        send_byte(0, 8'h40);
        send_byte(0, 8'h2A);
        @(negedge clk);
        in_data     = 8'hC0;
        in_valid    = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        check("coin_swap", 32'(swap_pending), 32'd1);
        check("coin_bg",   32'(background_color), 32'h15);
        pulse_frame(0);
        check("coin_bg_after", 32'(background_color), 32'h2A);
        check("coin_swapclr",  32'(swap_pending), 32'd0);

        // Partial POLY write to slot 2 leaves active bank alone
        send_byte(0, 8'h02);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        check("partial_color", 32'(poly_color), 32'h000C00);
        for (int i = 0; i < 5; i++) send_byte(0, 8'h00);
        // Slot 0 with truncating bytes, then BG/EN truncation
        send_byte(0, 8'h00);
        send_byte(0, 8'hC7);
        send_byte(0, 8'hFF);
        send_byte(0, 8'hFF);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
        send_byte(0, 8'h40);
        send_byte(0, 8'hFF);
        send_byte(0, 8'h80);
        send_byte(0, 8'hF5);
        send_byte(0, 8'hC0);
        check("trunc_pre_en", 32'(cmp_en), 32'd0);
        pulse_frame(0);
        check("trunc_bg",    32'(background_color), 32'h3F);
        check("trunc_en",    32'(cmp_en), 32'h5);
        check("trunc_color", 32'(poly_color), 32'h011C07);
        check("trunc_v0x",   32'(v0_x), 32'h008887F);
        check("trunc_v0y",   32'(v0_y), 32'h00017F);
        check("trunc_v2y",   32'(v2_y), 32'h000C00);

        // Invalid slot on the 2-slot instance
        check("inv_err_pre", 32'(cmd_error2), 32'd0);
        send_byte(1, 8'h03);
        for (int i = 0; i < 7; i++) send_byte(1, 8'h3F);
        check("inv_err", 32'(cmd_error2), 32'd1);
        send_byte(1, 8'hC0);
        pulse_frame(1);
        check("inv_color", 32'(poly_color2), 32'h000);
        check("inv_v0x",   32'(v0_x2), 32'h0000);
        check("inv_v2y",   32'(v2_y2), 32'h000);
        send_byte(1, 8'h01);
        send_byte(1, 8'h21);
        for (int i = 0; i < 6; i++) send_byte(1, 8'h00);
        send_byte(1, 8'hC0);
        pulse_frame(1);
        check("inv_resume_color", 32'(poly_color2), 32'h840);
        check("inv_err_sticky",   32'(cmd_error2), 32'd1);
        check("dut1_err_clear",   32'(cmd_error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
